// File: rtl/bus_pkg.sv
// bus_pkg: shared ID constants and helpers for bus endpoints.
package bus_pkg;
   localparam int ID_W = 8;
   localparam logic [ID_W-1:0] BROADCAST = 8'hFF;
   localparam int PKT_MAX = 256;
   function automatic logic [ID_W-1:0] get_dest(input logic [PKT_MAX-1:0] pkt, input int w);
      return ID_W'(pkt >> (w - ID_W));
   endfunction
   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return &v ? v : v + 8'd1;
   endfunction
endpackage

// File: rtl/ep_fifo.sv
// ep_fifo: first-word-fall-through FIFO; head reads 0 while empty.
module ep_fifo #(
   parameter int pckg_sz = 32,
   parameter int depth = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic wr_en,
   input  logic [pckg_sz-1:0] wr_data,
   input  logic rd_en,
   output logic full,
   output logic empty,
   output logic [pckg_sz-1:0] head,
   output logic [$clog2(depth+1)-1:0] count
);
   localparam int PW = $clog2(depth);
   localparam int CW = $clog2(depth+1);
   logic [pckg_sz-1:0] mem [depth];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic wr, rd;
   // depth need not be a power of two, so wrap explicitly
   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return p == PW'(depth-1) ? '0 : p + 1'b1;
   endfunction
   assign wr = wr_en && !full;
   assign rd = rd_en && !empty;
   assign full = count == CW'(depth);
   assign empty = count == '0;
   assign head = empty ? '0 : mem[rd_ptr];
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count <= '0;
      end else begin
         if (wr) wr_ptr <= nxt(wr_ptr);
         if (rd) rd_ptr <= nxt(rd_ptr);
         count <= count + CW'(wr) - CW'(rd);
      end
   always_ff @(posedge clk)
      if (wr) mem[wr_ptr] <= wr_data;
endmodule

// File: rtl/bus_endpoint.sv
// bus_endpoint: device-side terminal of one bus driver port, TX and RX FIFOs
// with drop/misroute counters and a sticky pop-underflow flag.
module bus_endpoint import bus_pkg::*; #(
   parameter int pckg_sz = 32,
   parameter int depth = 4,
   parameter logic [ID_W-1:0] my_id = 8'd0,
   parameter logic [ID_W-1:0] broadcast = BROADCAST
) (
   input  logic clk,
   input  logic reset,
   input  logic tx_valid,
   input  logic [pckg_sz-1:0] tx_data,
   output logic tx_ready,
   output logic pndng,
   output logic [pckg_sz-1:0] D_pop,
   input  logic pop,
   input  logic push,
   input  logic [pckg_sz-1:0] D_push,
   output logic rx_valid,
   output logic [pckg_sz-1:0] rx_data,
   input  logic rx_ready,
   output logic [7:0] rx_drop_cnt,
   output logic [7:0] misroute_cnt,
   output logic pop_err
);
   localparam int CW = $clog2(depth+1);
   logic tx_full, tx_empty, rx_full, rx_empty, misroute;
   logic [CW-1:0] tx_cnt, rx_cnt;
   logic [ID_W-1:0] dest;
   ep_fifo #(.pckg_sz(pckg_sz), .depth(depth)) u_tx (
      .clk(clk), .reset(reset), .wr_en(tx_valid), .wr_data(tx_data), .rd_en(pop),
      .full(tx_full), .empty(tx_empty), .head(D_pop), .count(tx_cnt)
   );
   ep_fifo #(.pckg_sz(pckg_sz), .depth(depth)) u_rx (
      .clk(clk), .reset(reset), .wr_en(push), .wr_data(D_push), .rd_en(rx_ready && !rx_empty),
      .full(rx_full), .empty(rx_empty), .head(rx_data), .count(rx_cnt)
   );
   assign tx_ready = !tx_full;
   assign pndng = tx_cnt != '0;
   assign rx_valid = rx_cnt != '0;
   assign dest = get_dest(PKT_MAX'(D_push), pckg_sz);
   assign misroute = dest != my_id && dest != broadcast;
   // full is pre-edge state, so a simultaneous dequeue never rescues a push
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         rx_drop_cnt <= '0;
         misroute_cnt <= '0;
         pop_err <= 1'b0;
      end else begin
         if (push && rx_full) rx_drop_cnt <= sat_inc8(rx_drop_cnt);
         if (push && !rx_full && misroute) misroute_cnt <= sat_inc8(misroute_cnt);
         if (pop && tx_empty) pop_err <= 1'b1;
      end
endmodule

// File: doc/bus_endpoint.md
Name: bus_endpoint

Overview:
- Device-side terminal for one drvr port of bs_gnrtr_n_rbtr; it is the other end of the per-port pndng/pop/D_pop and push/D_push interface.
- TX direction: holds outbound packets in a FIFO and presents the head to the bus via pndng/D_pop; the bus consumes it with pop.
- RX direction: captures packets the bus delivers via push/D_push into a second FIFO, and drains them to local logic through a valid/ready handshake.
- One instance per drvr; it replaces the behavioural FIFO model in the bench driver.

Parameters:
- pckg_sz, 32, packet width in bits; bits [pckg_sz-1:pckg_sz-8] hold the destination ID.
- depth, 4, entries per FIFO (TX and RX each); must be at least 2.
- my_id, 0, this endpoint's 8-bit ID, used for the RX address check.
- broadcast, 8'hFF, broadcast destination ID.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- tx_valid  in  1  local write request.
- tx_data  in  pckg_sz  local outbound packet.
- tx_ready  out  1  TX FIFO not full.
- pndng  out  1  TX FIFO not empty (to bus).
- D_pop  out  pckg_sz  TX head packet (to bus).
- pop  in  1  bus consumes the TX head.
- push  in  1  bus delivers a packet.
- D_push  in  pckg_sz  delivered packet.
- rx_valid  out  1  RX FIFO not empty.
- rx_data  out  pckg_sz  RX head packet.
- rx_ready  in  1  local consumer takes the RX head.
- rx_drop_cnt  out  8  count of pushes dropped because RX was full; saturating.
- misroute_cnt  out  8  count of accepted pushes whose destination is neither my_id nor broadcast; saturating.
- pop_err  out  1  sticky flag: pop was asserted while TX was empty.

Behaviour:
- Reset (reset low, asynchronous): both FIFOs empty, pointers 0, pndng=0, rx_valid=0, tx_ready=1, counters 0, pop_err=0; D_pop and rx_data are driven 0 while empty.
- Both FIFOs are first-word-fall-through:
  - D_pop equals the TX head whenever pndng=1.
  - rx_data equals the RX head whenever rx_valid=1.
- TX write: accepted at a rising edge when tx_valid && tx_ready. pndng rises after that same edge, so a write at edge N can be popped at edge N+1.
- tx_ready = !tx_full, purely from state; there is no combinational path from pop.
  - tx_valid while full: ignored, data lost; the producer must honour tx_ready.
- TX pop: at a rising edge with pop && pndng, the head advances. D_pop shows the next entry, or 0 if TX is now empty, after that edge.
  - pop && !pndng: no state change; pop_err is set and held until reset.
- TX write and pop at the same edge while not empty and not full: both occur and the count is unchanged.
  - When full: the pop occurs and the write is refused (tx_ready was 0).
  - When empty: the write occurs, the pop is an error (pop_err set).
- RX push: at a rising edge with push, if the RX FIFO is not full, D_push is stored.
  - If full: the packet is dropped and rx_drop_cnt increments (saturates at 255).
  - Push and rx_ready at the same edge while full: the dequeue happens and the push is still dropped. Full is evaluated from pre-edge state.
- RX address check applies to stored packets only. If D_push[pckg_sz-1 -: 8] != my_id and != broadcast, misroute_cnt increments (saturates at 255). The packet is still stored.
- RX dequeue: at a rising edge with rx_valid && rx_ready. rx_ready while empty has no effect.
- Pointers are log2(depth)-bit and wrap modulo depth. Occupancy counters are clog2(depth+1) bits. depth need not be a power of 2, so pointers wrap explicitly at depth-1.
- Reset asserted mid-operation clears all state immediately. Packets in flight are discarded.

Decomposition:
- Package bus_pkg:
  - ID_W = 8
  - BROADCAST = 8'hFF
  - function get_dest(pkt) returning the top ID_W bits
  - saturating 8-bit increment function
- Sub-module ep_fifo (parameters pckg_sz, depth): FWFT FIFO with wr_en, rd_en, full, empty, head, count, and asynchronous active-low reset.
  - Instantiated twice, as TX and RX.
  - Status logic, the address check and the counters live in bus_endpoint.

Test Plan:
All scenarios use pckg_sz=32, depth=4, my_id=3.
1. Reset, then write tx_data=32'h0300_00AA -> pndng=1 and D_pop=32'h0300_00AA one edge after the write. Pop at the next edge -> pndng=0, D_pop=0.
2. Write 4 packets 1..4 without popping -> tx_ready=0 after the 4th. A 5th write is ignored. Then 4 pops return 1,2,3,4 in order with pndng falling after the last pop.
3. Pop while TX empty -> pop_err=1, FIFO state unchanged; pop_err stays 1 until reset is asserted low.
4. Push 6 packets with rx_ready=0 -> rx_valid=1, the first 4 are stored, rx_drop_cnt=2. Drain with rx_ready=1 -> data returned in order.
5. Push D_push=32'h0500_0001 (dest 5) and 32'hFF00_0002 (broadcast) -> both stored, misroute_cnt=1.
6. With 2 entries in each FIFO, assert reset low between edges -> pndng=0, rx_valid=0 and counters 0 immediately, without waiting for a clock edge.
